// File: rtl/serial_demux_1x8_pkg.sv
// Shared constants and state encoding for the 1-to-8 serial demultiplexer.
// Word width and index width are fixed together: SEL_W must equal log2(WIDTH).
package serial_demux_1x8_pkg;

  localparam int WIDTH = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/serial_demux_1x8_if.sv
// Serial-in / parallel-out bundle between a bit source and the demultiplexer.
// The master drives the serial side; the slave (the demultiplexer) drives the word side.
interface serial_demux_1x8_if;
  import serial_demux_1x8_pkg::*;

  logic             start;
  logic             din;
  logic             din_valid;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             busy;
  logic             frame_err;

  modport master (
    output start, din, din_valid,
    input  dout, dout_valid, busy, frame_err
  );

  modport slave (
    input  start, din, din_valid,
    output dout, dout_valid, busy, frame_err
  );

endinterface

// File: rtl/serial_demux_1x8_demux.sv
// Combinational 1-to-8 demultiplexer built as a tree of 1-to-2 stages,
// mirroring the serializer's mux tree: sel[2] splits first, sel[0] last.
module demux_1x8 (
  input  logic       d,
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] y
);

  logic       root;
  logic [1:0] lvl1;
  logic [3:0] lvl2;

  assign root    = d & en;
  assign lvl1[0] = root & ~sel[2];
  assign lvl1[1] = root &  sel[2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_lvl2
    assign lvl2[2*gi]   = lvl1[gi] & ~sel[1];
    assign lvl2[2*gi+1] = lvl1[gi] &  sel[1];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_leaf
    assign y[2*gi]   = lvl2[gi] & ~sel[0];
    assign y[2*gi+1] = lvl2[gi] &  sel[0];
  end

endmodule

// File: rtl/serial_demux_1x8.sv
// Reassembles an LSB-first serial stream into 8-bit words with a one-cycle
// valid strobe; a start during a frame aborts it and flags frame_err.
module serial_demux_1x8
  import serial_demux_1x8_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  serial_demux_1x8_if.slave  bus
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   slot_q, slot_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               frame_err_q, frame_err_d;

  logic               accept;
  logic [SEL_W-1:0]   wr_sel;
  logic [WIDTH-1:0]   wr_en;
  logic [WIDTH-1:0]   slot_base;
  logic [WIDTH-1:0]   slot_wr;

  // A start always restarts at bit 0 on a cleared slot register.
  assign accept    = bus.din_valid & (bus.start | (state_q == COLLECT));
  assign wr_sel    = bus.start ? '0 : idx_q;
  assign slot_base = bus.start ? '0 : slot_q;

  demux_1x8 u_demux (
    .d   (1'b1),
    .en  (accept),
    .sel (wr_sel),
    .y   (wr_en)
  );

  assign slot_wr = (slot_base & ~wr_en) | (wr_en & {WIDTH{bus.din}});

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    slot_d       = slot_wr;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = COLLECT;
          idx_d   = bus.din_valid ? SEL_W'(1) : SEL_W'(0);
        end
      end
      COLLECT: begin
        if (bus.start) begin
          frame_err_d = 1'b1;
          idx_d       = bus.din_valid ? SEL_W'(1) : SEL_W'(0);
        end else if (bus.din_valid) begin
          if (idx_q == LAST_IDX) begin
            dout_d       = slot_wr;
            dout_valid_d = 1'b1;
            idx_d        = '0;
            state_d      = IDLE;
          end else begin
            idx_d = idx_q + SEL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      slot_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      slot_q       <= slot_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state_q == COLLECT);

endmodule

// File: tb/tb_serial_demux_1x8.sv
// Directed bench for serial_demux_1x8: expected words are queued as frames are
// driven and matched against each dout_valid strobe by a negedge monitor.
module tb_serial_demux_1x8;

  logic clk = 1'b0;
  logic rst;
  int   assertions = 0;
  int   failures   = 0;
  int   cyc        = 0;
  int   err_seen   = 0;
  int   err_exp    = 0;
  logic [7:0] exp_q[$];
  int         strobe_cyc[$];

  serial_demux_1x8_if bus ();

  serial_demux_1x8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    assertions++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Inputs change 1 time unit after a rising edge and are sampled at the next one.
  task automatic cycle(input logic s, input logic d, input logic v);
    bus.start     = s;
    bus.din       = d;
    bus.din_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_rest(input logic [7:0] w, input int from_k);
    for (int k = from_k; k < 8; k++) begin
      if (k == 7) exp_q.push_back(w);
      cycle(1'b0, w[k], 1'b1);
    end
  endtask

  task automatic send_frame(input logic [7:0] w);
    cycle(1'b1, w[0], 1'b1);
    send_rest(w, 1);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.dout_valid === 1'b1) begin
        strobe_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          assertions++;
          assert (0)
          else begin
            failures++;
            $error("FAIL unexpected_strobe: observed dout=%0h expected no strobe", bus.dout);
          end
        end else begin
          chk("sb_dout", 32'(bus.dout), 32'(exp_q.pop_front()));
        end
      end
      if (bus.frame_err === 1'b1) err_seen++;
      chk("valid_err_exclusive", 32'(bus.dout_valid & bus.frame_err), 32'd0);
    end
  end

  initial begin
    logic [7:0] w;
    rst = 1'b1;
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("rst_dout", 32'(bus.dout), 32'h0);
    chk("rst_dout_valid", 32'(bus.dout_valid), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'h0);

    // Plain frame 0xA5.
    w = 8'hA5;
    cycle(1'b1, w[0], 1'b1);
    chk("a5_busy_first", 32'(bus.busy), 32'h1);
    send_rest(w, 1);
    chk("a5_dout", 32'(bus.dout), 32'hA5);
    chk("a5_valid", 32'(bus.dout_valid), 32'h1);
    chk("a5_busy_done", 32'(bus.busy), 32'h0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("a5_valid_one_cycle", 32'(bus.dout_valid), 32'h0);

    // 0x3C with three idle cycles after bits 2 and 5.
    w = 8'h3C;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) exp_q.push_back(w);
      cycle(k == 0, w[k], 1'b1);
      if (k == 2 || k == 5) begin
        repeat (3) begin
          cycle(1'b0, ~w[k], 1'b0);
          chk("gap_busy", 32'(bus.busy), 32'h1);
          chk("gap_valid", 32'(bus.dout_valid), 32'h0);
        end
      end
    end
    chk("3c_dout", 32'(bus.dout), 32'h3C);

    // Abort after 4 bits of 0xFF, restart with 0x12 on the same cycle.
    cycle(1'b1, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b1, 1'b1);
    w = 8'h12;
    cycle(1'b1, w[0], 1'b1);
    err_exp++;
    chk("abort_frame_err", 32'(bus.frame_err), 32'h1);
    chk("abort_dout_hold", 32'(bus.dout), 32'h3C);
    chk("abort_no_valid", 32'(bus.dout_valid), 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'h1);
    cycle(1'b0, w[1], 1'b1);
    chk("abort_err_one_cycle", 32'(bus.frame_err), 32'h0);
    chk("abort_dout_still", 32'(bus.dout), 32'h3C);
    send_rest(w, 2);
    chk("12_dout", 32'(bus.dout), 32'h12);

    // Back-to-back: 0x81, then start without data next cycle, then 0x7E.
    cycle(1'b0, 1'b0, 1'b0);
    strobe_cyc.delete();
    send_frame(8'h81);
    cycle(1'b1, 1'b0, 1'b0);
    chk("b2b_busy_after_start", 32'(bus.busy), 32'h1);
    chk("b2b_first_dout", 32'(bus.dout), 32'h81);
    send_rest(8'h7E, 0);
    chk("7e_dout", 32'(bus.dout), 32'h7E);
    cycle(1'b0, 1'b0, 1'b0);
    chk("b2b_strobe_count", 32'(strobe_cyc.size()), 32'd2);
    if (strobe_cyc.size() == 2)
      chk("b2b_strobe_gap", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd9);

    // Reset after 5 bits discards the partial word.
    cycle(1'b1, 1'b1, 1'b1);
    repeat (4) cycle(1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    cycle(1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    chk("midrst_dout", 32'(bus.dout), 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    chk("midrst_valid", 32'(bus.dout_valid), 32'h0);
    send_frame(8'h55);
    chk("55_dout", 32'(bus.dout), 32'h55);

    // Valid data with no start while idle is ignored.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), 1'(i % 2 == 0));
      chk("noise_busy", 32'(bus.busy), 32'h0);
      chk("noise_valid", 32'(bus.dout_valid), 32'h0);
      chk("noise_dout", 32'(bus.dout), 32'h55);
    end

    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("frame_err_count", 32'(err_seen), 32'(err_exp));
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
